uart_aes_block_bridge: RTL and testbench

//  Byte-stream <-> AES block bridge between UART rx/tx byte engines and an AES core (start/done).

---
 rtl/uart_aes_pkg.sv | 16 +
 rtl/uart_aes_block_fifo.sv | 40 ++++
 rtl/uart_aes_block_bridge.sv | 168 ++++++++++++++++
 tb/tb_uart_aes_block_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_aes_pkg.sv
// Shared constants for the UART <-> AES block bridge: block geometry, FSM encoding, default key.
package uart_aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_ISSUE   = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  localparam logic [BLOCK_W-1:0] DEFAULT_KEY_C = 128'h5468617473206d79204b756e67204675;

  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/uart_aes_block_fifo.sv
// Result block FIFO, DEPTH x W; pointers carry one extra wrap bit so full and empty differ.
module uart_aes_block_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);

endmodule

// File: rtl/uart_aes_block_bridge.sv
// Byte stream <-> AES block bridge with run-time key, direction and buffered results.
// Define UART_AES_CBC_EN to add CBC chaining; the default build is ECB.
//
// state   | meaning
// COLLECT | packing rx bytes into the block register
// HOLD    | block complete, waiting for result space
// ISSUE   | one-cycle aes_start, block and direction on the core inputs
// WAIT    | core busy; result pushed on aes_done
module uart_aes_block_bridge
  import uart_aes_pkg::*;
#(
  parameter int     OUT_DEPTH   = 4,
  parameter block_t DEFAULT_KEY = DEFAULT_KEY_C,
  parameter block_t CBC_IV      = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               key_wr,
  input  logic [BLOCK_W-1:0] key_wdata,
  input  logic               mode_dec,
  input  logic               flush,
  output logic [BLOCK_W-1:0] aes_din,
  output logic [BLOCK_W-1:0] aes_key,
  output logic               aes_dec,
  output logic               aes_start,
  input  logic [BLOCK_W-1:0] aes_dout,
  input  logic               aes_done,
  output logic               busy,
  output logic               overrun,
  output logic               key_err
);

  localparam int CW = $clog2(OUT_DEPTH);

  logic [1:0]  state;
  logic [3:0]  byte_cnt;
  block_t      block_q;
  block_t      key_q;
  logic        dec_q;
  block_t      tx_sh;
  logic [3:0]  tx_cnt;
  logic        tx_active;

  logic [CW:0]   fifo_count;
  logic          fifo_empty;
  block_t        fifo_rdata;
  block_t        push_data;
  block_t        din_calc;
  logic          push;
  logic          pop;
  logic          inflight;
  logic          dec_now;
  logic          space;
  logic          last_byte;
  logic [CW+1:0] occ;

  assign inflight  = (state == ST_ISSUE) || (state == ST_WAIT);
  assign dec_now   = (state == ST_ISSUE) ? mode_dec : dec_q;
  assign last_byte = (byte_cnt == 4'(BLOCK_BYTES-1));

  // The block held by the serialiser still counts against capacity.
  assign occ   = {1'b0, fifo_count} + (CW+2)'(inflight) + (CW+2)'(tx_active);
  assign space = (occ < (CW+2)'(OUT_DEPTH));

  assign push = (state == ST_WAIT) && aes_done;
  assign pop  = !fifo_empty && (!tx_active || (tx_ready && tx_cnt == 4'(BLOCK_BYTES-1)));

`ifdef UART_AES_CBC_EN
  block_t chain_q;

  assign din_calc  = dec_now ? block_q : (block_q ^ chain_q);
  assign push_data = dec_q ? (aes_dout ^ chain_q) : aes_dout;

  always_ff @(posedge clk) begin
    if (!rst_n)     chain_q <= CBC_IV;
    else if (flush) chain_q <= CBC_IV;
    else if (push)  chain_q <= dec_q ? block_q : aes_dout;
  end
`else
  assign din_calc  = block_q;
  // CBC_IV has no role in ECB; the masked term only keeps the parameter referenced.
  assign push_data = aes_dout | (CBC_IV & '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_COLLECT;
      byte_cnt <= '0;
      block_q  <= '0;
      key_q    <= DEFAULT_KEY;
      dec_q    <= 1'b0;
      overrun  <= 1'b0;
      key_err  <= 1'b0;
    end else begin
      if (rx_valid && !flush && state != ST_COLLECT) overrun <= 1'b1;
      if (key_wr) begin
        if (state == ST_COLLECT && byte_cnt == '0) key_q <= key_wdata;
        else                                       key_err <= 1'b1;
      end
      case (state)
        ST_COLLECT: begin
          if (flush) begin
            byte_cnt <= '0;
          end else if (rx_valid) begin
            block_q <= {block_q[BLOCK_W-9:0], rx_byte};
            if (last_byte) state <= space ? ST_ISSUE : ST_HOLD;
            else           byte_cnt <= byte_cnt + 4'd1;
          end
        end
        ST_HOLD:  if (space) state <= ST_ISSUE;
        ST_ISSUE: begin
          byte_cnt <= '0;
          dec_q    <= mode_dec;
          state    <= ST_WAIT;
        end
        ST_WAIT:  if (aes_done) state <= ST_COLLECT;
        default:  state <= ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh     <= '0;
      tx_cnt    <= '0;
      tx_active <= 1'b0;
    end else if (pop) begin
      tx_sh     <= fifo_rdata;
      tx_cnt    <= '0;
      tx_active <= 1'b1;
    end else if (tx_active && tx_ready) begin
      if (tx_cnt == 4'(BLOCK_BYTES-1)) begin
        tx_active <= 1'b0;
      end else begin
        tx_sh  <= {tx_sh[BLOCK_W-9:0], 8'h00};
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  uart_aes_block_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (BLOCK_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign aes_start = (state == ST_ISSUE);
  assign aes_din   = inflight ? din_calc : '0;
  assign aes_dec   = inflight & dec_now;
  assign aes_key   = key_q;
  assign tx_byte   = tx_sh[BLOCK_W-1 -: 8];
  assign tx_valid  = tx_active;
  assign busy      = (state != ST_COLLECT) || !fifo_empty || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_aes_block_bridge.sv
// Self-checking bench for uart_aes_block_bridge: directed scenarios plus random blocks against a block-level model.
module tb_uart_aes_block_bridge;

  localparam logic [127:0] KD = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] C2 = 128'h29c3505f571420f6402299b31a02d73a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         key_wr;
  logic [127:0] key_wdata;
  logic         mode_dec;
  logic         flush;
  logic [127:0] aes_din;
  logic [127:0] aes_key;
  logic         aes_dec;
  logic         aes_start;
  logic [127:0] aes_dout;
  logic         aes_done;
  logic         busy;
  logic         overrun;
  logic         key_err;

  always #5 clk = ~clk;

  uart_aes_block_bridge dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .key_wr(key_wr), .key_wdata(key_wdata), .mode_dec(mode_dec), .flush(flush),
    .aes_din(aes_din), .aes_key(aes_key), .aes_dec(aes_dec), .aes_start(aes_start),
    .aes_dout(aes_dout), .aes_done(aes_done), .busy(busy), .overrun(overrun), .key_err(key_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_blocks = 0;
  int n_issued = 0;
  int n_done = 0;
  int core_lat = 0;
  bit rdy_hold = 1'b1;
  logic [127:0] m_key = KD;
  logic [127:0] m_chain = '0;
  logic [7:0]   got_q[$];
  logic [7:0]   exp_q[$];
  logic [128:0] exp_din_q[$];
  logic [128:0] issued_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in AES: FIPS-197 vectors by table, otherwise an invertible keyed byte rotation.
  function automatic logic [127:0] aes_ref(input logic [127:0] x, input logic [127:0] k, input logic d);
    logic [127:0] t;
    if (k == K1 && !d && x == P1) return C1;
    if (k == K1 &&  d && x == C1) return P1;
    if (k == KD && !d && x == P2) return C2;
    if (k == KD &&  d && x == C2) return P2;
    if (!d) return {x[119:0], x[127:120]} ^ k;
    t = x ^ k;
    return {t[7:0], t[127:8]};
  endfunction

  function automatic void predict(input logic [127:0] blk, input logic d,
                                  output logic [127:0] din, output logic [127:0] res);
`ifdef UART_AES_CBC_EN
    if (!d) begin
      din = blk ^ m_chain;
      res = aes_ref(din, m_key, 1'b0);
      m_chain = res;
    end else begin
      din = blk;
      res = aes_ref(blk, m_key, 1'b1) ^ m_chain;
      m_chain = blk;
    end
`else
    din = blk ^ (m_chain & '0);
    res = aes_ref(blk, m_key, d);
`endif
  endfunction

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = rdy_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && tx_valid && tx_ready) got_q.push_back(tx_byte);
    end
  end

  // Core model: latch inputs on aes_start, answer after a latency.
  initial begin
    logic [127:0] din, k;
    logic d;
    int lat;
    aes_done = 1'b0;
    aes_dout = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n === 1'b1 && aes_start === 1'b1) begin
        din = aes_din; k = aes_key; d = aes_dec;
        n_issued++;
        issued_q.push_back({d, din});
        lat = (core_lat != 0) ? core_lat : int'($urandom_range(1, 4));
        repeat (lat) @(negedge clk);
        chk("key_stable", aes_key, k);
        aes_dout = aes_ref(din, k, d);
        aes_done = 1'b1;
        n_done++;
        @(negedge clk);
        aes_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk);
    logic [127:0] din, res;
    predict(blk, mode_dec, din, res);
    exp_din_q.push_back({mode_dec, din});
    for (int i = 0; i < 16; i++) exp_q.push_back(res[127-8*i -: 8]);
    n_blocks++;
    for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
  endtask

  task automatic finish_all();
    logic [128:0] e, o;
    for (int i = 0; i < 1000 && n_done < n_blocks; i++) @(negedge clk);
    chk("core_done", n_done, n_blocks);
    @(negedge clk);
    while (exp_din_q.size() > 0) begin
      e = exp_din_q.pop_front();
      o = (issued_q.size() > 0) ? issued_q.pop_front() : 'x;
      chk("aes_din_dec", o, e);
    end
  endtask

  task automatic drain();
    logic [7:0] e, g;
    for (int i = 0; i < 4000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk("tx_byte", g, e);
    end
    chk("tx_extra", got_q.size(), 0);
  endtask

  task automatic key_write(input logic [127:0] k);
    @(negedge clk);
    key_wr = 1'b1;
    key_wdata = k;
    @(negedge clk);
    key_wr = 1'b0;
    m_key = k;
    #1 chk("aes_key_wr", aes_key, k);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_chain = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_key = KD;
    m_chain = '0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] blk, r1, r2;
    int base;
    rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; key_wr = 1'b0; key_wdata = '0;
    mode_dec = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_aes_start", aes_start, 1'b0);
    chk("rst_aes_din", aes_din, 128'h0);
    chk("rst_aes_dec", aes_dec, 1'b0);
    chk("rst_aes_key", aes_key, KD);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    rdy_hold = 1'b0;

    // FIPS-197 vector, issue latency and pulse width
    key_write(K1);
    send_block(P1);
    #1;
    chk("t1_start", aes_start, 1'b1);
    chk("t1_din", aes_din, P1);
    chk("t1_dec", aes_dec, 1'b0);
    @(negedge clk); #1;
    chk("t1_start_pulse", aes_start, 1'b0);
    finish_all();
    drain();

    // Default key after reset
    do_reset();
    @(negedge clk); #1;
    chk("t2_key_default", aes_key, KD);
    send_block(P2);
    finish_all();
    drain();

    // Partial block flushed; flush beats a simultaneous rx byte
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    @(negedge clk);
    flush = 1'b1; rx_valid = 1'b1; rx_byte = 8'hee;
    @(negedge clk);
    flush = 1'b0; rx_valid = 1'b0;
    m_chain = '0;
    #1;
    chk("t4_busy_after_flush", busy, 1'b0);
    chk("t4_no_overrun", overrun, 1'b0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_block(blk);
    finish_all();
    drain();

    // Random key, random direction, random tx back-pressure
    key_write({$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 6; n++) begin
      mode_dec = 1'($urandom_range(0, 1));
      send_block({$urandom, $urandom, $urandom, $urandom});
      finish_all();
    end
    drain();
    chk("rand_key_err", key_err, 1'b0);

    // Decrypt of the FIPS vector; key write during WAIT is refused
    core_lat = 4;
    flush_pulse();
    key_write(K1);
    mode_dec = 1'b1;
    send_block(C1);
    #1 chk("t5_dec", aes_dec, 1'b1);
    @(negedge clk);
    key_wr = 1'b1; key_wdata = ~K1;
    @(negedge clk);
    key_wr = 1'b0;
    #1;
    chk("t5_key_err", key_err, 1'b1);
    chk("t5_key_kept", aes_key, K1);
    finish_all();
    drain();
    core_lat = 0;
    mode_dec = 1'b0;

    // Back-pressure: four blocks buffered, fifth held, extra byte dropped
    rdy_hold = 1'b1;
    base = n_issued;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(16*k + i + 1);
      send_block(blk);
      if (k < 4) finish_all();
    end
    repeat (5) @(negedge clk);
    chk("t3_issued", n_issued - base, 4);
    chk("t3_overrun_before", overrun, 1'b0);
    send_byte(8'h51);
    #1;
    chk("t3_overrun", overrun, 1'b1);
    chk("t3_busy", busy, 1'b1);
    rdy_hold = 1'b0;
    drain();
    finish_all();

`ifdef UART_AES_CBC_EN
    // Chaining: identical plaintext blocks, then decrypt back
    flush_pulse();
    mode_dec = 1'b0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    r1 = aes_ref(blk, m_key, 1'b0);
    r2 = aes_ref(blk ^ r1, m_key, 1'b0);
    send_block(blk);
    finish_all();
    send_block(blk);
    finish_all();
    drain();
    flush_pulse();
    mode_dec = 1'b1;
    send_block(r1);
    finish_all();
    send_block(r2);
    finish_all();
    drain();
    mode_dec = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
